hello_message_streamer: RTL and testbench

Synthesizable source stage that emits the fixed ASCII message "Hello from design!" plus a line feed, one byte per transfer, over a valid/ready byte stream. It is the design-side producer instantiated by the hello-world test bench, which consumes and displays the stream. A start pulse triggers a burst of `REPEAT_COUNT` messages separated by programmable idle gaps, with a done pulse at the end.

---
 rtl/hello_message_streamer.sv | 168 ++++++++++++++++
 tb/tb_hello_message_streamer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hello_message_streamer.sv
// Streams "Hello from design!\n" byte by byte over valid/ready, repeated
// REPEAT_COUNT times per start pulse with GAP_CYCLES idle cycles between messages.
module hello_message_streamer #(
  parameter int unsigned REPEAT_COUNT = 2,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] byte_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] LAST_IDX = 5'd18;
  localparam logic [7:0] REP_LAST = 8'(REPEAT_COUNT - 1);
  // Gap counter counts down to zero, so it is loaded one short of the gap length.
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  function automatic logic [7:0] rom_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'h48;
      5'd1:    b = 8'h65;
      5'd2:    b = 8'h6C;
      5'd3:    b = 8'h6C;
      5'd4:    b = 8'h6F;
      5'd5:    b = 8'h20;
      5'd6:    b = 8'h66;
      5'd7:    b = 8'h72;
      5'd8:    b = 8'h6F;
      5'd9:    b = 8'h6D;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h64;
      5'd12:   b = 8'h65;
      5'd13:   b = 8'h73;
      5'd14:   b = 8'h69;
      5'd15:   b = 8'h67;
      5'd16:   b = 8'h6E;
      5'd17:   b = 8'h21;
      5'd18:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  rep_q, rep_d;
  logic [7:0]  gap_q, gap_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        xfer;

  assign xfer = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcnt_d  = bcnt_q;

    if (xfer && bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SEND;
          idx_d   = 5'd0;
          rep_d   = 8'd0;
          valid_d = 1'b1;
          data_d  = rom_byte(5'd0);
          busy_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            if (rep_q < REP_LAST) begin
              rep_d = rep_q + 8'd1;
              idx_d = 5'd0;
              if (GAP_CYCLES == 0) begin
                data_d = rom_byte(5'd0);
              end else begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
                valid_d = 1'b0;
              end
            end else begin
              state_d = S_DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d  = idx_q + 5'd1;
            data_d = rom_byte(idx_q + 5'd1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = S_SEND;
          idx_d   = 5'd0;
          valid_d = 1'b1;
          data_d  = rom_byte(5'd0);
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      rep_q   <= 8'd0;
      gap_q   <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign byte_count_o = bcnt_q;

endmodule

// File: tb/tb_hello_message_streamer.sv
// Bench for hello_message_streamer: three instances with different burst shapes,
// checked cycle by cycle against an expected byte stream built from the message text.
module tb_hello_message_streamer;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_v   [ND];
  logic        start_v [ND];
  logic        ready_v [ND];
  logic        valid_v [ND];
  logic [7:0]  data_v  [ND];
  logic        busy_v  [ND];
  logic        done_v  [ND];
  logic [15:0] bc_v    [ND];

  int checks   = 0;
  int failures = 0;
  int rep_m [ND] = '{1, 2, 3};
  int gap_m [ND] = '{4, 4, 0};
  int bc_m  [ND];
  string msg = "Hello from design!\n";

  always #5 clk = ~clk;

  hello_message_streamer #(.REPEAT_COUNT(1), .GAP_CYCLES(4)) u0 (
    .clk(clk), .rst(rst_v[0]), .start_i(start_v[0]), .ready_i(ready_v[0]),
    .valid_o(valid_v[0]), .data_o(data_v[0]), .busy_o(busy_v[0]),
    .done_o(done_v[0]), .byte_count_o(bc_v[0]));

  hello_message_streamer #(.REPEAT_COUNT(2), .GAP_CYCLES(4)) u1 (
    .clk(clk), .rst(rst_v[1]), .start_i(start_v[1]), .ready_i(ready_v[1]),
    .valid_o(valid_v[1]), .data_o(data_v[1]), .busy_o(busy_v[1]),
    .done_o(done_v[1]), .byte_count_o(bc_v[1]));

  hello_message_streamer #(.REPEAT_COUNT(3), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .start_i(start_v[2]), .ready_i(ready_v[2]),
    .valid_o(valid_v[2]), .data_o(data_v[2]), .busy_o(busy_v[2]),
    .done_o(done_v[2]), .byte_count_o(bc_v[2]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_valid", int'(valid_v[d]), 0);
    chk("rst_data",  int'(data_v[d]),  0);
    chk("rst_busy",  int'(busy_v[d]),  0);
    chk("rst_done",  int'(done_v[d]),  0);
    chk("rst_bcnt",  int'(bc_v[d]),    0);
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  // abort_at > 0 asserts reset once that many bytes have transferred.
  task automatic run_burst(input int d, input int rmode, input bit poke_start, input int abort_at);
    int pos, total, low_run, last_gap_pos;
    bit prev_valid, prev_xfer, r, done_seen, aborted;
    total = rep_m[d] * 19;
    pos = 0; low_run = 0; last_gap_pos = 0;
    prev_valid = 0; prev_xfer = 0; done_seen = 0; aborted = 0;
    @(negedge clk);
    chk("idle_busy", int'(busy_v[d]), 0);
    start_v[d] = 1'b1;
    ready_v[d] = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b0;
    chk("lat_valid", int'(valid_v[d]), 1);
    chk("lat_busy",  int'(busy_v[d]),  1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (abort_at > 0 && pos == abort_at) begin
        rst_v[d] = 1'b1;
        #1;
        chk_reset(d);
        @(negedge clk);
        chk("abort_done", int'(done_v[d]), 0);
        rst_v[d]   = 1'b0;
        start_v[d] = 1'b0;
        ready_v[d] = 1'b0;
        bc_m[d]    = 0;
        aborted    = 1;
        break;
      end
      chk("bcnt", int'(bc_v[d]), bc_m[d] & 32'hFFFF);
      if (prev_valid && !prev_xfer) chk("hold_valid", int'(valid_v[d]), 1);
      if (done_v[d]) begin
        chk("done_pos",   pos, total);
        chk("done_valid", int'(valid_v[d]), 0);
        done_seen = 1;
        break;
      end else if (valid_v[d]) begin
        if (pos >= total) chk("overrun", pos, total - 1);
        else chk("data", int'(data_v[d]), int'(msg[pos % 19]));
        if (pos > 0 && pos % 19 == 0 && last_gap_pos != pos) begin
          chk("gap_len", low_run, gap_m[d]);
          last_gap_pos = pos;
        end
        low_run = 0;
      end else begin
        low_run++;
        chk("gap_busy", int'(busy_v[d]), 1);
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready_v[d] = r;
      if (poke_start) start_v[d] = ($urandom_range(0, 3) == 0);
      prev_valid = valid_v[d];
      prev_xfer  = valid_v[d] && r;
      if (prev_xfer) begin
        pos++;
        if (bc_m[d] < 65535) bc_m[d]++;
      end
    end
    start_v[d] = 1'b0;
    if (!aborted) begin
      if (!done_seen) chk("timeout", 0, 1);
      @(negedge clk);
      chk("done_clr", int'(done_v[d]), 0);
      chk("busy_clr", int'(busy_v[d]), 0);
      chk("end_bcnt", int'(bc_v[d]), bc_m[d]);
      ready_v[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst_v[d] = 1'b1; start_v[d] = 1'b0; ready_v[d] = 1'b0; bc_m[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) chk_reset(d);
    for (int d = 0; d < ND; d++) rst_v[d] = 1'b0;
    repeat (2) @(negedge clk);

    run_burst(0, 0, 1'b0, 0);
    run_burst(0, 1, 1'b0, 0);
    run_burst(1, 0, 1'b0, 0);
    run_burst(2, 0, 1'b0, 0);
    run_burst(1, 2, 1'b1, 0);
    run_burst(1, 0, 1'b1, 0);
    run_burst(0, 0, 1'b0, 7);
    run_burst(0, 2, 1'b0, 0);
    run_burst(2, 2, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
